// File: rtl/bldc_defs_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bldc_defs_pkg : Hall decode, sector encoding and gate-pair patterns    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package bldc_defs_pkg;

  typedef logic [2:0] sector_t;

  typedef struct packed {
    logic    valid;
    sector_t sector;
  } hall_dec_t;

  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } gate_pair_t;

  localparam logic [2:0] PH_A = 3'b001;
  localparam logic [2:0] PH_B = 3'b010;
  localparam logic [2:0] PH_C = 3'b100;

  // Codes 0 and 7 are physically impossible for 120-degree sensors.
  function automatic hall_dec_t hall_to_sector(input logic [2:0] hall);
    hall_dec_t d;
    d.valid  = 1'b1;
    d.sector = 3'd0;
    case (hall)
      3'd1:    d.sector = 3'd0;
      3'd5:    d.sector = 3'd1;
      3'd4:    d.sector = 3'd2;
      3'd6:    d.sector = 3'd3;
      3'd2:    d.sector = 3'd4;
      3'd3:    d.sector = 3'd5;
      default: d.valid  = 1'b0;
    endcase
    return d;
  endfunction

  function automatic sector_t sector_shift(input sector_t s, input logic dir);
    if (!dir)
      return s;
    return (s >= 3'd3) ? (s - 3'd3) : (s + 3'd3);
  endfunction

  function automatic gate_pair_t sector_pair(input sector_t s);
    gate_pair_t p;
    p.hi = 3'b000;
    p.lo = 3'b000;
    case (s)
      3'd0:    begin p.hi = PH_A; p.lo = PH_B; end
      3'd1:    begin p.hi = PH_A; p.lo = PH_C; end
      3'd2:    begin p.hi = PH_B; p.lo = PH_C; end
      3'd3:    begin p.hi = PH_B; p.lo = PH_A; end
      3'd4:    begin p.hi = PH_C; p.lo = PH_A; end
      3'd5:    begin p.hi = PH_C; p.lo = PH_B; end
      default: begin p.hi = 3'b000; p.lo = 3'b000; end
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dead_time_leg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dead_time_leg : delays each side's turn-on, removes turn-off at once   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dead_time_leg #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic req_h,
  input  logic req_l,
  output logic gate_h,
  output logic gate_l
);

  localparam int             CW       = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0]  DEAD_MAX = CW'(DEAD_CYCLES);

  logic          want_h, want_l;
  logic [CW-1:0] cnt_h_q, cnt_h_d;
  logic [CW-1:0] cnt_l_q, cnt_l_d;

  // A conflicting request pair never counts, so neither side can sneak on.
  assign want_h = req_h & ~req_l;
  assign want_l = req_l & ~req_h;

  always_comb begin
    cnt_h_d = '0;
    cnt_l_d = '0;
    if (want_h)
      cnt_h_d = (cnt_h_q == DEAD_MAX) ? cnt_h_q : cnt_h_q + 1'b1;
    if (want_l)
      cnt_l_d = (cnt_l_q == DEAD_MAX) ? cnt_l_q : cnt_l_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_h_q <= '0;
      cnt_l_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_l_q <= cnt_l_d;
    end
  end

  assign gate_h = want_h & (cnt_h_q == DEAD_MAX);
  assign gate_l = want_l & (cnt_l_q == DEAD_MAX);

endmodule
`default_nettype wire

// File: rtl/bldc_commutator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bldc_commutator : six-step commutation with Hall debounce and PWM      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module bldc_commutator
  import bldc_defs_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TICK_IN,
  input  logic                EN,
  input  logic                DIR,
  input  logic [PWM_BITS-1:0] DUTY,
  input  logic [2:0]          HALL,
  output logic [2:0]          GATE_H,
  output logic [2:0]          GATE_L,
  output logic [2:0]          SECTOR,
  output logic                FAULT
);

  localparam int            SW        = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(DEBOUNCE);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE - 1);

  logic [2:0]          tick_sync_q, tick_sync_d;
  logic                tick_q, tick_d;
  logic [2:0]          hall_s1_q, hall_s1_d, hall_s2_q, hall_s2_d;
  logic [2:0]          cand_q, cand_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d, duty_q, duty_d;
  sector_t             sector_q, sector_d;
  logic                valid_q, valid_d, fault_q, fault_d;

  logic                accept, pwm_on, drive;
  hall_dec_t           dec;
  gate_pair_t          pair;
  logic [2:0]          req_h, req_l;

  always_comb begin
    tick_sync_d = {tick_sync_q[1:0], TICK_IN};
    tick_d      = tick_sync_q[1] & ~tick_sync_q[2];
    hall_s1_d   = HALL;
    hall_s2_d   = hall_s1_q;

    cand_d = cand_q;
    stab_d = stab_q;
    accept = 1'b0;
    if (hall_s2_q != cand_q) begin
      cand_d = hall_s2_q;
      stab_d = '0;
    end else if (tick_q && (stab_q != STAB_MAX)) begin
      stab_d = stab_q + 1'b1;
      accept = (stab_q == STAB_LAST);
    end

    dec      = hall_to_sector(cand_q);
    sector_d = sector_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    if (accept) begin
      if (dec.valid) begin
        sector_d = dec.sector;
        valid_d  = 1'b1;
      end else begin
        fault_d  = 1'b1;
      end
    end
    // Disabling the drive is the only way to acknowledge a Hall fault.
    if (!EN)
      fault_d = 1'b0;

    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (!EN) begin
      cnt_d = '0;
    end else if (tick_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {PWM_BITS{1'b1}})
        duty_d = DUTY;
    end

    pwm_on = (cnt_q < duty_q);
    drive  = EN & ~fault_q & valid_q;
    pair   = sector_pair(sector_shift(sector_q, DIR));
    req_h  = pair.hi & {3{drive & pwm_on}};
    req_l  = pair.lo & {3{drive}};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_sync_q <= '0;
      tick_q      <= 1'b0;
      hall_s1_q   <= '0;
      hall_s2_q   <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      cnt_q       <= '0;
      duty_q      <= '0;
      sector_q    <= 3'd0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      tick_sync_q <= tick_sync_d;
      tick_q      <= tick_d;
      hall_s1_q   <= hall_s1_d;
      hall_s2_q   <= hall_s2_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      sector_q    <= sector_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

  genvar leg;
  generate
    for (leg = 0; leg < 3; leg++) begin : g_leg
      dead_time_leg #(
        .DEAD_CYCLES (DEAD_CYCLES)
      ) u_leg (
        .CLK    (CLK),
        .RST    (RST),
        .req_h  (req_h[leg]),
        .req_l  (req_l[leg]),
        .gate_h (GATE_H[leg]),
        .gate_l (GATE_L[leg])
      );
    end
  endgenerate

  assign SECTOR = sector_q;
  assign FAULT  = fault_q;

endmodule
`default_nettype wire
